jtkiwi_pcm_seq: RTL and testbench

Sequencer for the Kageki PCM voice channel. It divides the FM chip's sample strobe into the PCM sample rate and handles trigger edges from YM2203 port B. It reads a two-byte start pointer from the sample table, then streams unsigned 8-bit samples from the PCM ROM until it hits a terminator. It sits between the sound subsystem's YM2203 port B and the PCM ROM slot, and its output feeds the DC-removal filter and the mixer.

---
 rtl/jtkiwi_pcm_pkg.sv | 20 ++
 rtl/jtkiwi_pcm_seq_if.sv | 23 ++
 rtl/jtkiwi_pcm_div.sv | 42 ++++
 rtl/jtkiwi_pcm_seq.sv | 145 ++++++++++++++
 tb/tb_jtkiwi_pcm_seq.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtkiwi_pcm_pkg.sv
// Shared definitions for the Kageki PCM voice sequencer.
package jtkiwi_pcm_pkg;

    // FSM state codes; the encoding is visible on the debug st port.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlo  = 2'd1,
        StPhi  = 2'd2,
        StPlay = 2'd3
    } pcm_st_e;

    localparam logic [7:0]  SilenceDef = 8'h80;
    localparam logic [15:0] TblBaseDef = 16'h0090;

    // Byte address of the two-byte pointer entry for a sample number.
    function automatic logic [15:0] tbl_addr(input logic [15:0] base, input logic [5:0] idx);
        return base + {9'd0, idx, 1'b0};
    endfunction

endpackage

// File: rtl/jtkiwi_pcm_seq_if.sv
// PCM ROM slot bus between the sequencer (master) and the ROM (slave).
interface jtkiwi_pcm_seq_if;

    logic [15:0] rom_addr;
    logic        rom_cs;
    logic [7:0]  rom_data;
    logic        rom_ok;

    modport master (
        output rom_addr,
        output rom_cs,
        input  rom_data,
        input  rom_ok
    );

    modport slave (
        input  rom_addr,
        input  rom_cs,
        output rom_data,
        output rom_ok
    );

endinterface

// File: rtl/jtkiwi_pcm_div.sv
// Divides rising edges of the FM sample strobe into the PCM tick rate.
module jtkiwi_pcm_div #(
    parameter int unsigned DIV = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_i,
    output logic pcm_cen_o
);

    logic           sample_q;
    logic [DIV-1:0] ring_q, ring_d;
    logic           pcm_cen_q, pcm_cen_d;
    logic           smp_rise;

    assign smp_rise  = sample_i & ~sample_q;
    assign pcm_cen_o = pcm_cen_q;

    // Rotate the one-hot ring once per strobe edge; tick on the edge that sees the top bit.
    always_comb begin
        ring_d    = ring_q;
        pcm_cen_d = 1'b0;
        if (smp_rise) begin
            ring_d    = (ring_q << 1) | (ring_q >> (DIV - 1));
            pcm_cen_d = ring_q[DIV-1];
        end
    end

    // Edge detector delay, ring and registered tick pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q  <= 1'b0;
            ring_q    <= DIV'(1);
            pcm_cen_q <= 1'b0;
        end else begin
            sample_q  <= sample_i;
            ring_q    <= ring_d;
            pcm_cen_q <= pcm_cen_d;
        end
    end

endmodule

// File: rtl/jtkiwi_pcm_seq.sv
// Kageki PCM voice sequencer: trigger handling, pointer fetch and sample streaming.
module jtkiwi_pcm_seq
    import jtkiwi_pcm_pkg::*;
#(
    parameter logic [15:0] TBL_BASE = TblBaseDef,
    parameter int unsigned DIV      = 3,
    parameter logic [7:0]  SILENCE  = SilenceDef
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sample,
    input  logic                      trig,
    input  logic [5:0]                idx,
    jtkiwi_pcm_seq_if.master          rom,
    output logic [7:0]                pcm,
    output logic                      pcm_cen,
    output logic                      busy,
    output logic [1:0]                st
);

    pcm_st_e     st_q, st_d;
    logic [15:0] addr_q, addr_d, addr_last_q;
    logic        cs_q, cs_d;
    logic [7:0]  pcm_q, pcm_d;
    logic [7:0]  lo_q, lo_d;
    logic        pend_q, pend_d;
    logic        last_q, last_d;
    logic        trig_q;
    logic        trig_rise;
    logic        accept;
    logic        take;

    jtkiwi_pcm_div #(
        .DIV (DIV)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .sample_i  (sample),
        .pcm_cen_o (pcm_cen)
    );

    assign trig_rise = trig & ~trig_q;
    // rom_ok is only trusted once the address has been stable for a full cycle.
    assign accept    = cs_q & rom.rom_ok & (addr_q == addr_last_q) & ~trig_rise;
    // A tick seen now or earlier allows one PLAY byte.
    assign take      = pend_q | pcm_cen;

    assign rom.rom_addr = addr_q;
    assign rom.rom_cs   = cs_q;
    assign pcm          = pcm_q;
    assign busy         = (st_q != StIdle);
    assign st           = st_q;

    // Next-state logic: trigger overrides everything, then per-state fetch handling.
    always_comb begin
        st_d   = st_q;
        addr_d = addr_q;
        cs_d   = cs_q;
        pcm_d  = pcm_q;
        lo_d   = lo_q;
        pend_d = pend_q;
        last_d = last_q;
        if (trig_rise) begin
            st_d   = StPlo;
            addr_d = tbl_addr(TBL_BASE, idx);
            cs_d   = 1'b1;
            pend_d = 1'b0;
            last_d = 1'b0;
        end else begin
            unique case (st_q)
                StIdle: begin
                    cs_d = 1'b0;
                end
                StPlo: begin
                    if (accept) begin
                        lo_d   = rom.rom_data;
                        addr_d = addr_q + 16'd1;
                        st_d   = StPhi;
                    end
                end
                StPhi: begin
                    if (accept) begin
                        addr_d = {rom.rom_data, lo_q};
                        st_d   = StPlay;
                    end
                end
                StPlay: begin
                    if (last_q) begin
                        // Byte at 0xFFFF already played; stop on the following tick.
                        if (take) begin
                            st_d   = StIdle;
                            pcm_d  = SILENCE;
                            cs_d   = 1'b0;
                            pend_d = 1'b0;
                            last_d = 1'b0;
                        end
                    end else if (take && accept) begin
                        if (rom.rom_data == 8'd0) begin
                            st_d   = StIdle;
                            pcm_d  = SILENCE;
                            cs_d   = 1'b0;
                            pend_d = 1'b0;
                        end else begin
                            pcm_d  = rom.rom_data;
                            pend_d = 1'b0;
                            if (addr_q == 16'hFFFF) begin
                                last_d = 1'b1;
                            end else begin
                                addr_d = addr_q + 16'd1;
                            end
                        end
                    end else if (pcm_cen) begin
                        pend_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= StIdle;
            addr_q      <= 16'd0;
            addr_last_q <= 16'd0;
            cs_q        <= 1'b0;
            pcm_q       <= SILENCE;
            lo_q        <= 8'd0;
            pend_q      <= 1'b0;
            last_q      <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            st_q        <= st_d;
            addr_q      <= addr_d;
            addr_last_q <= addr_q;
            cs_q        <= cs_d;
            pcm_q       <= pcm_d;
            lo_q        <= lo_d;
            pend_q      <= pend_d;
            last_q      <= last_d;
            trig_q      <= trig;
        end
    end

endmodule

// File: tb/tb_jtkiwi_pcm_seq.sv
// Self-checking bench for jtkiwi_pcm_seq with a ROM model and a stream reference model.
module tb_jtkiwi_pcm_seq;

    localparam logic [15:0] TBL = 16'h0090;
    localparam logic [7:0]  SIL = 8'h80;

    logic       clk;
    logic       rst;
    logic       sample;
    logic       trig;
    logic [5:0] idx;
    logic [7:0] pcm;
    logic       pcm_cen;
    logic       busy;
    logic [1:0] st;

    jtkiwi_pcm_seq_if rom_bus ();

    jtkiwi_pcm_seq #(
        .TBL_BASE (TBL),
        .DIV      (3),
        .SILENCE  (SIL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sample  (sample),
        .trig    (trig),
        .idx     (idx),
        .rom     (rom_bus),
        .pcm     (pcm),
        .pcm_cen (pcm_cen),
        .busy    (busy),
        .st      (st)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] rom_mem [0:65535];
    logic [7:0] exp_q [$];

    bit samp_run  = 0;
    bit samp_man  = 0;
    bit stale_mode = 0;
    bit hold_low  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // FM strobe: free-running square wave (period 8 clocks) or manual level.
    initial begin
        int cnt;
        cnt = 0;
        sample = 1'b0;
        forever begin
            @(negedge clk);
            if (samp_run) begin
                cnt++;
                if (cnt == 4) begin
                    sample = ~sample;
                    cnt = 0;
                end
            end else begin
                sample = samp_man;
            end
        end
    end

    // ROM model: random latency after each address change, or a one-cycle-late
    // data path with rom_ok stuck high to exercise stale data rejection.
    initial begin
        logic [15:0] seen;
        int lat;
        seen = 16'd0;
        lat = 0;
        rom_bus.rom_data = 8'd0;
        rom_bus.rom_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (stale_mode) begin
                rom_bus.rom_data = rom_mem[seen];
                rom_bus.rom_ok = 1'b1;
                seen = rom_bus.rom_addr;
            end else begin
                if (rom_bus.rom_addr != seen) begin
                    seen = rom_bus.rom_addr;
                    lat = $urandom_range(0, 3);
                end else if (lat != 0) begin
                    lat--;
                end
                rom_bus.rom_ok = (lat == 0) && !hold_low;
                rom_bus.rom_data = rom_bus.rom_ok ? rom_mem[seen] : 8'($urandom);
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_addr"}, rom_bus.rom_addr, 16'h0000);
        check_val({tag, "_cs"}, rom_bus.rom_cs, 1'b0);
        check_val({tag, "_pcm"}, pcm, SIL);
        check_val({tag, "_cen"}, pcm_cen, 1'b0);
        check_val({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_st"}, st, 2'd0);
    endtask

    // Expected played bytes: stop before a zero, or after the byte at 0xFFFF.
    task automatic build_exp(input logic [15:0] ptr);
        logic [15:0] a;
        a = ptr;
        exp_q.delete();
        for (int n = 0; n < 256; n++) begin
            if (rom_mem[a] == 8'd0) break;
            exp_q.push_back(rom_mem[a]);
            if (a == 16'hFFFF) break;
            a = a + 16'd1;
        end
    endtask

    task automatic wait_state(input logic [1:0] target, output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (st == target) begin
                ok = 1;
                return;
            end
        end
        check_val("state_timeout", {30'd0, st}, {30'd0, target});
    endtask

    task automatic wait_tick(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pcm_cen && st == 2'd3) begin
                ok = 1;
                return;
            end
        end
        check_val("tick_timeout", 0, 1);
    endtask

    task automatic trigger(input int ix);
        @(negedge clk);
        trig = 1'b0;
        @(negedge clk);
        idx = 6'(ix);
        trig = 1'b1;
        @(negedge clk);
        check_val("trig_addr", rom_bus.rom_addr, TBL + 16'(2 * ix));
        check_val("trig_cs", rom_bus.rom_cs, 1'b1);
        check_val("trig_st", st, 2'd1);
    endtask

    task automatic check_stream(input int ix, input logic [7:0] prev);
        logic [15:0] ent;
        logic [15:0] ptr;
        logic [7:0]  last;
        bit ok;
        ent = TBL + 16'(2 * ix);
        ptr = {rom_mem[ent + 16'd1], rom_mem[ent]};
        build_exp(ptr);
        wait_state(2'd2, ok);
        if (!ok) return;
        check_val("phi_addr", rom_bus.rom_addr, ent + 16'd1);
        wait_state(2'd3, ok);
        if (!ok) return;
        check_val("play_addr", rom_bus.rom_addr, ptr);
        last = prev;
        for (int k = 0; k <= exp_q.size(); k++) begin
            wait_tick(ok);
            if (!ok) return;
            check_val("pcm_hold", pcm, last);
            repeat (8) @(negedge clk);
            if (k < exp_q.size()) begin
                check_val("pcm_byte", pcm, exp_q[k]);
                check_val("busy_play", busy, 1'b1);
                last = exp_q[k];
            end else begin
                check_val("end_pcm", pcm, SIL);
                check_val("end_busy", busy, 1'b0);
                check_val("end_st", st, 2'd0);
                check_val("end_cs", rom_bus.rom_cs, 1'b0);
            end
        end
    endtask

    task automatic set_ptr(input int ix, input logic [15:0] p);
        rom_mem[TBL + 16'(2 * ix)] = p[7:0];
        rom_mem[TBL + 16'(2 * ix) + 16'd1] = p[15:8];
    endtask

    initial begin
        bit ok;
        int cnt;
        int total;
        logic [15:0] p;
        int len;
        logic [7:0] b0, b1;

        rst = 1'b1;
        trig = 1'b0;
        idx = 6'd0;
        for (int i = 0; i < 65536; i++) rom_mem[i] = 8'd0;

        // Sample table contents.
        set_ptr(5, 16'h1234);
        rom_mem[16'h1234] = 8'h40;
        rom_mem[16'h1235] = 8'hC0;
        rom_mem[16'h1236] = 8'h00;
        set_ptr(7, 16'h2000);
        for (int j = 0; j < 6; j++) rom_mem[16'h2000 + 16'(j)] = 8'(8'h11 * (j + 1));
        set_ptr(9, 16'hFFFF);
        rom_mem[16'hFFFF] = 8'h5A;
        set_ptr(0, 16'h5000);
        for (int j = 0; j < 3; j++) rom_mem[16'h5000 + 16'(j)] = 8'($urandom_range(1, 255));
        set_ptr(11, 16'h5100);
        for (int j = 0; j < 5; j++) rom_mem[16'h5100 + 16'(j)] = 8'($urandom_range(1, 255));
        for (int ix = 12; ix < 20; ix++) begin
            p = 16'h6000 + 16'(ix * 64);
            set_ptr(ix, p);
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) rom_mem[p + 16'(j)] = 8'($urandom_range(1, 255));
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Divider: 9 manual strobe edges give ticks on edges 3, 6 and 9.
        total = 0;
        for (int e = 1; e <= 9; e++) begin
            cnt = 0;
            #1 samp_man = 1'b1;
            repeat (3) begin
                @(negedge clk);
                cnt += int'(pcm_cen);
            end
            #1 samp_man = 1'b0;
            repeat (3) begin
                @(negedge clk);
                cnt += int'(pcm_cen);
            end
            check_val("div_edge", cnt, (e % 3 == 0) ? 1 : 0);
            total += cnt;
        end
        check_val("div_total", total, 3);
        samp_run = 1;

        // Basic play.
        trigger(5);
        check_stream(5, SIL);

        // Stale rom_ok: data lags the address by a cycle, rom_ok stays high.
        #1 stale_mode = 1;
        trigger(5);
        check_stream(5, SIL);
        #1 stale_mode = 0;

        // Retrigger mid-play.
        trigger(11);
        wait_state(2'd3, ok);
        wait_tick(ok);
        repeat (8) @(negedge clk);
        b0 = rom_mem[16'h5100];
        check_val("retrig_b0", pcm, b0);
        wait_tick(ok);
        repeat (8) @(negedge clk);
        b1 = rom_mem[16'h5101];
        check_val("retrig_b1", pcm, b1);
        trigger(0);
        check_val("retrig_pcm", pcm, b1);
        check_stream(0, b1);

        // Late data across two ticks.
        trigger(7);
        wait_state(2'd3, ok);
        wait_tick(ok);
        repeat (10) @(negedge clk);
        check_val("late_first", pcm, 8'h11);
        check_val("late_addr0", rom_bus.rom_addr, 16'h2001);
        #1 hold_low = 1;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            cnt += int'(pcm_cen);
        end
        check_val("late_ticks", (cnt >= 2), 1);
        check_val("late_wait", pcm, 8'h11);
        #1 hold_low = 0;
        @(negedge clk);
        check_val("late_pre", pcm, 8'h11);
        @(negedge clk);
        check_val("late_pcm", pcm, 8'h22);
        check_val("late_addr1", rom_bus.rom_addr, 16'h2002);
        if (!pcm_cen) begin
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (pcm_cen) break;
            end
            check_val("late_noextra", rom_bus.rom_addr, 16'h2002);
            check_val("late_noextra_pcm", pcm, 8'h22);
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check_val("late_done", busy, 1'b0);
        check_val("late_done_pcm", pcm, SIL);

        // Pointer 0xFFFF with nonzero data.
        trigger(9);
        check_stream(9, SIL);

        // Random sample numbers, random ROM mode.
        for (int r = 0; r < 8; r++) begin
            int ix;
            ix = $urandom_range(12, 19);
            #1 stale_mode = bit'($urandom_range(0, 1));
            trigger(ix);
            check_stream(ix, SIL);
        end
        #1 stale_mode = 0;

        // Reset during PLAY.
        trigger(11);
        wait_state(2'd3, ok);
        wait_tick(ok);
        repeat (8) @(negedge clk);
        check_val("rst_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
